// File: rtl/mvm_pkg.sv
// Shared constants and state encoding for the 3x3 matrix-vector host endpoint.
package mvm_pkg;

  localparam int N      = 3;
  localparam int DIN_W  = 8;
  localparam int DOUT_W = 16;
  localparam int W      = N * N + N;

  // Pointer widths: send pointer spans 0..W-1, receive pointer spans 0..N-1.
  localparam int SPTR_W = 4;
  localparam int RPTR_W = 2;
  localparam int LAT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mvm3_host.sv
// Host endpoint: buffers one 3x3 job, streams it out, collects 3 results.
//
// Handshake semantics (both streams): a word moves on every rising edge where
// valid && ready are both high. The master side (m_valid/data_out) never drops
// valid or changes data while ready is low. The slave side only raises s_ready
// in RECV, so s_valid at any other time is simply not consumed.
module mvm3_host
  import mvm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [SPTR_W-1:0]   wr_addr,
  input  logic [DIN_W-1:0]    wr_data,
  input  logic                start,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DIN_W-1:0]    data_out,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DOUT_W-1:0]   data_in,
  output logic                busy,
  output logic                done,
  input  logic [RPTR_W-1:0]   rd_addr,
  output logic [DOUT_W-1:0]   rd_data,
  output logic [LAT_W-1:0]    lat_cycles,
  output logic [1:0]          state_dbg
);

  state_e              state_q, state_d;
  logic [SPTR_W-1:0]   send_ptr_q, send_ptr_d;
  logic [RPTR_W-1:0]   recv_ptr_q, recv_ptr_d;
  logic                m_valid_q, m_valid_d;
  logic [DIN_W-1:0]    data_out_q, data_out_d;
  logic                s_ready_q, s_ready_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DIN_W-1:0]    buf_q [0:W-1];
  logic [DIN_W-1:0]    buf_d [0:W-1];
  logic [DOUT_W-1:0]   res_q [0:N-1];
  logic [DOUT_W-1:0]   res_d [0:N-1];

  logic                idle_or_done;
  logic                wr_ok;
  logic                start_ok;
  logic                m_xfer;
  logic                s_xfer;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign wr_ok        = wr_en && idle_or_done && (wr_addr < SPTR_W'(W));
  assign start_ok     = start && idle_or_done;
  assign m_xfer       = m_valid_q && m_ready;
  assign s_xfer       = s_valid && s_ready_q;

  // Next-state, datapath and handshake control.
  always_comb begin
    state_d    = state_q;
    send_ptr_d = send_ptr_q;
    recv_ptr_d = recv_ptr_q;
    m_valid_d  = m_valid_q;
    data_out_d = data_out_q;
    s_ready_d  = s_ready_q;
    lat_d      = lat_q;
    buf_d      = buf_q;
    res_d      = res_q;

    // The write is applied before start samples word 0, so a same-cycle
    // write to address 0 is what goes out first.
    if (wr_ok) begin
      buf_d[wr_addr] = wr_data;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d    = SEND;
          send_ptr_d = '0;
          recv_ptr_d = '0;
          m_valid_d  = 1'b1;
          data_out_d = buf_d[0];
          s_ready_d  = 1'b0;
          lat_d      = '0;
        end
      end
      SEND: begin
        if (m_xfer) begin
          if (send_ptr_q == SPTR_W'(W - 1)) begin
            state_d    = RECV;
            m_valid_d  = 1'b0;
            data_out_d = '0;
            s_ready_d  = 1'b1;
            recv_ptr_d = '0;
          end else begin
            send_ptr_d = send_ptr_q + SPTR_W'(1);
            data_out_d = buf_q[send_ptr_q + SPTR_W'(1)];
          end
        end
      end
      RECV: begin
        if (s_xfer) begin
          res_d[recv_ptr_q] = data_in;
          if (recv_ptr_q == RPTR_W'(N - 1)) begin
            state_d   = DONE;
            s_ready_d = 1'b0;
          end else begin
            recv_ptr_d = recv_ptr_q + RPTR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Latency counts every cycle spent in SEND or RECV and sticks at all-ones.
    if (!start_ok && (state_q == SEND || state_q == RECV) && (lat_q != '1)) begin
      lat_d = lat_q + LAT_W'(1);
    end
  end

  // State, pointers, handshake outputs and counters; reset abandons any job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      send_ptr_q <= '0;
      recv_ptr_q <= '0;
      m_valid_q  <= 1'b0;
      data_out_q <= '0;
      s_ready_q  <= 1'b0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      send_ptr_q <= send_ptr_d;
      recv_ptr_q <= recv_ptr_d;
      m_valid_q  <= m_valid_d;
      data_out_q <= data_out_d;
      s_ready_q  <= s_ready_d;
      lat_q      <= lat_d;
    end
  end

  // Job buffer and result registers, cleared asynchronously with the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < W; i++) buf_q[i] <= '0;
      for (int i = 0; i < N; i++) res_q[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) buf_q[i] <= buf_d[i];
      for (int i = 0; i < N; i++) res_q[i] <= res_d[i];
    end
  end

  assign m_valid    = m_valid_q;
  assign data_out   = data_out_q;
  assign s_ready    = s_ready_q;
  assign busy       = (state_q == SEND) || (state_q == RECV);
  assign done       = (state_q == DONE);
  assign lat_cycles = lat_q;
  assign state_dbg  = state_q;
  assign rd_data    = (rd_addr < RPTR_W'(N)) ? res_q[rd_addr] : '0;

endmodule

// File: tb/tb_mvm3_host.sv
// Self-checking bench for mvm3_host: stream scoreboard plus directed checks.
module tb_mvm3_host;
  import mvm_pkg::*;

  logic               clk;
  logic               reset;
  logic               wr_en;
  logic [3:0]         wr_addr;
  logic [7:0]         wr_data;
  logic               start;
  logic               m_valid;
  logic               m_ready;
  logic [7:0]         data_out;
  logic               s_valid;
  logic               s_ready;
  logic [15:0]        data_in;
  logic               busy;
  logic               done;
  logic [1:0]         rd_addr;
  logic [15:0]        rd_data;
  logic [15:0]        lat_cycles;
  logic [1:0]         state_dbg;

  logic [7:0]         exp_q [$];
  logic [7:0]         exp_buf [0:11];
  int                 cmp_cnt;
  int                 fail_cnt;
  int                 tx_count;
  logic               hold_pending;
  logic [7:0]         held_word;

  mvm3_host dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .data_out   (data_out),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .lat_cycles (lat_cycles),
    .state_dbg  (state_dbg)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act on. Checks each transferred word and stall stability.
  always @(negedge clk) begin
    if (hold_pending) begin
      check("stall_hold_valid", {31'd0, m_valid}, 32'd1);
      check("stall_hold_data", {24'd0, data_out}, {24'd0, held_word});
      hold_pending = 1'b0;
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {24'd0, data_out}, 32'hFFFF_FFFF);
      end else begin
        check("stream_word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
      tx_count++;
    end else if (m_valid && !m_ready) begin
      hold_pending = 1'b1;
      held_word    = data_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    if (a < 12) exp_buf[a] = d;
  endtask

  task automatic push_job();
    for (int i = 0; i < 12; i++) exp_q.push_back(exp_buf[i]);
  endtask

  task automatic launch();
    push_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic launch_with_write(input int a, input logic [7:0] d);
    exp_buf[a] = d;
    push_job();
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    start   = 1'b1;
    tick();
    wr_en   = 1'b0;
    start   = 1'b0;
  endtask

  // Drive m_ready until n more words have moved; toggle mode uses 1,0,0,...
  task automatic run_send(input int n, input bit toggle, input bit inject, output int cycles);
    int target;
    target = tx_count + n;
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      m_ready = toggle ? (i % 3 == 0) : 1'b1;
      if (inject) begin
        s_valid = 1'b1;
        data_in = 16'h5555;
        wr_en   = (i == 2);
        wr_addr = 4'd0;
        wr_data = 8'h7F;
      end
      tick();
      cycles++;
      if (tx_count >= target) break;
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    wr_en   = 1'b0;
    if (tx_count < target) check("send_timeout", tx_count, target);
  endtask

  task automatic send_results(input logic [15:0] r0, input logic [15:0] r1,
                              input logic [15:0] r2, input int delay);
    logic [15:0] r [0:2];
    r[0] = r0; r[1] = r1; r[2] = r2;
    repeat (delay) tick();
    for (int k = 0; k < 3; k++) begin
      int w;
      s_valid = 1'b1;
      data_in = r[k];
      w = 0;
      while (!s_ready && w < 100) begin
        tick();
        w++;
      end
      if (!s_ready) check("recv_timeout", 0, 1);
      tick();
    end
    s_valid = 1'b0;
    data_in = 16'h0;
  endtask

  task automatic check_results(input string tag, input logic [15:0] r0,
                               input logic [15:0] r1, input logic [15:0] r2);
    logic [15:0] r [0:2];
    r[0] = r0; r[1] = r1; r[2] = r2;
    for (int k = 0; k < 4; k++) begin
      rd_addr = 2'(k);
      #1;
      check($sformatf("%s_rd%0d", tag, k), {16'd0, rd_data}, (k < 3) ? {16'd0, r[k]} : 32'd0);
    end
  endtask

  initial begin
    int cyc;
    cmp_cnt = 0; fail_cnt = 0; tx_count = 0;
    hold_pending = 1'b0; held_word = '0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    m_ready = 1'b0; s_valid = 1'b0; data_in = '0; rd_addr = '0;
    for (int i = 0; i < 12; i++) exp_buf[i] = 8'h00;

    // Reset state.
    repeat (2) tick();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_lat", {16'd0, lat_cycles}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    check_results("rst", 16'd0, 16'd0, 16'd0);
    reset = 1'b1;
    tick();

    // Basic job: M = 1..9, x = {1,2,3} -> {14,32,50}.
    for (int i = 0; i < 9; i++) write_word(i, 8'(i + 1));
    for (int i = 0; i < 3; i++) write_word(9 + i, 8'(i + 1));
    write_word(12, 8'hAA);
    launch();
    check("send_busy", {31'd0, busy}, 32'd1);
    check("send_s_ready", {31'd0, s_ready}, 32'd0);
    run_send(12, 1'b0, 1'b0, cyc);
    check("send_cycles", cyc, 12);
    check("recv_s_ready", {31'd0, s_ready}, 32'd1);
    check("recv_m_valid", {31'd0, m_valid}, 32'd0);
    send_results(16'd14, 16'd32, 16'd50, 0);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_busy", {31'd0, busy}, 32'd0);
    check("basic_lat", {16'd0, lat_cycles}, 32'd15);
    check_results("basic", 16'd14, 16'd32, 16'd50);
    tick();
    check("lat_frozen", {16'd0, lat_cycles}, 32'd15);

    // Backpressure with ignored write, early s_valid and start during RECV.
    launch();
    run_send(12, 1'b1, 1'b1, cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_recv_state", {30'd0, state_dbg}, {30'd0, RECV});
    check("start_in_recv_sready", {31'd0, s_ready}, 32'd1);
    send_results(16'hFFF9, 16'd100, 16'hFED4, 5);
    check("bp_done", {31'd0, done}, 32'd1);
    check_results("bp", 16'hFFF9, 16'd100, 16'hFED4);

    // Rerun from DONE with no new writes: buf[0] must still be 1.
    launch();
    check("rerun_done_clear", {31'd0, done}, 32'd0);
    check("rerun_lat_clear", {16'd0, lat_cycles}, 32'd0);
    run_send(12, 1'b0, 1'b0, cyc);
    send_results(16'd7, 16'd8, 16'd9, 1);
    check("rerun_done", {31'd0, done}, 32'd1);
    check_results("rerun", 16'd7, 16'd8, 16'd9);

    // Write and start together: word 0 goes out as the new value.
    launch_with_write(0, 8'h80);
    run_send(12, 1'b0, 1'b0, cyc);
    send_results(16'h8000, 16'h7FFF, 16'h0001, 0);
    check_results("samecyc", 16'h8000, 16'h7FFF, 16'h0001);

    // Reset after the 5th transfer.
    launch();
    run_send(5, 1'b0, 1'b0, cyc);
    reset = 1'b0;
    #1;
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    check_results("midrst", 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 12; i++) exp_buf[i] = 8'h00;

    // Zero job after reset, with a long result stall to saturate lat_cycles.
    launch();
    run_send(12, 1'b0, 1'b0, cyc);
    repeat (70000) tick();
    check("sat_lat", {16'd0, lat_cycles}, 32'h0000_FFFF);
    check("sat_busy", {31'd0, busy}, 32'd1);
    send_results(16'd1, 16'd2, 16'd3, 0);
    check("sat_done", {31'd0, done}, 32'd1);
    check("sat_lat_end", {16'd0, lat_cycles}, 32'h0000_FFFF);
    check_results("sat", 16'd1, 16'd2, 16'd3);

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
